// File: rtl/sensor_conditioner.sv
// Front end for the two-road traffic-light FSM: per-road synchronize/debounce with
// rising-edge pulses, plus the free-running one-cycle tick that paces the FSM.

module sc_channel #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          s_sync;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  assign s_sync = sync_q[1];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d   = cnt_q;
    level_d = level_q;
    if (s_sync == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s_sync;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Registered alongside the level so the pulse lines up with the first cycle it reads 1.
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync_q  <= {sync_q[0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

module sc_tick #(
  parameter int unsigned TICK_PERIOD = 100000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int unsigned TW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_PERIOD - 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    tcnt_d = tcnt_q + 1'b1;
    tick_d = 1'b0;
    if (tcnt_q == TCNT_LAST) begin
      tcnt_d = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

module sensor_conditioner #(
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned TICK_PERIOD = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic sa_raw,
  input  logic sb_raw,
  output logic sa,
  output logic sb,
  output logic sa_rise,
  output logic sb_rise,
  output logic tick
);

  sc_channel #(.DB_CYCLES(DB_CYCLES)) u_chan_a (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (sa_raw),
    .level_o (sa),
    .rise_o  (sa_rise)
  );

  sc_channel #(.DB_CYCLES(DB_CYCLES)) u_chan_b (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (sb_raw),
    .level_o (sb),
    .rise_o  (sb_rise)
  );

  sc_tick #(.TICK_PERIOD(TICK_PERIOD)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

endmodule
